// File: rtl/ps2_pkg.sv
// Shared scan codes, key-state indices, movement bit positions and receiver
// state type for the PS/2 movement decoder.
package ps2_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned KEY_W     = 8;
  localparam int unsigned KEY_IDX_W = 3;
  localparam int unsigned MVMT_W    = 4;

  // Set 2 scan codes of interest
  localparam logic [BYTE_W-1:0] SC_W     = 8'h1D;
  localparam logic [BYTE_W-1:0] SC_S     = 8'h1B;
  localparam logic [BYTE_W-1:0] SC_A     = 8'h1C;
  localparam logic [BYTE_W-1:0] SC_D     = 8'h23;
  localparam logic [BYTE_W-1:0] SC_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] SC_DOWN  = 8'h72;
  localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;
  localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_OVR0  = 8'h00;
  localparam logic [BYTE_W-1:0] SC_OVR1  = 8'hFF;

  // Movement vector bit positions, same order as raycaster mvmt_in
  localparam int unsigned MVMT_UP    = 3;
  localparam int unsigned MVMT_DOWN  = 2;
  localparam int unsigned MVMT_LEFT  = 1;
  localparam int unsigned MVMT_RIGHT = 0;

  // Per-key pressed-state bit positions
  localparam int unsigned KEY_UP_W      = 7;
  localparam int unsigned KEY_DOWN_S    = 6;
  localparam int unsigned KEY_LEFT_A    = 5;
  localparam int unsigned KEY_RIGHT_D   = 4;
  localparam int unsigned KEY_UP_ARR    = 3;
  localparam int unsigned KEY_DOWN_ARR  = 2;
  localparam int unsigned KEY_LEFT_ARR  = 1;
  localparam int unsigned KEY_RIGHT_ARR = 0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  typedef struct packed {
    logic                 hit;
    logic [KEY_IDX_W-1:0] idx;
  } key_lookup_t;

  // Map (extended prefix, scan code) to a key-state index
  function automatic key_lookup_t key_lookup(input logic ext, input logic [BYTE_W-1:0] code);
    key_lookup_t r;
    r.hit = 1'b1;
    r.idx = '0;
    if (!ext) begin
      case (code)
        SC_W:    r.idx = KEY_IDX_W'(KEY_UP_W);
        SC_S:    r.idx = KEY_IDX_W'(KEY_DOWN_S);
        SC_A:    r.idx = KEY_IDX_W'(KEY_LEFT_A);
        SC_D:    r.idx = KEY_IDX_W'(KEY_RIGHT_D);
        default: r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    r.idx = KEY_IDX_W'(KEY_UP_ARR);
        SC_DOWN:  r.idx = KEY_IDX_W'(KEY_DOWN_ARR);
        SC_LEFT:  r.idx = KEY_IDX_W'(KEY_LEFT_ARR);
        SC_RIGHT: r.idx = KEY_IDX_W'(KEY_RIGHT_ARR);
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

  // WASD and arrow keys for the same direction are merged
  function automatic logic [MVMT_W-1:0] mvmt_from_keys(input logic [KEY_W-1:0] k);
    logic [MVMT_W-1:0] m;
    m = '0;
    m[MVMT_UP]    = k[KEY_UP_W]    | k[KEY_UP_ARR];
    m[MVMT_DOWN]  = k[KEY_DOWN_S]  | k[KEY_DOWN_ARR];
    m[MVMT_LEFT]  = k[KEY_LEFT_A]  | k[KEY_LEFT_ARR];
    m[MVMT_RIGHT] = k[KEY_RIGHT_D] | k[KEY_RIGHT_ARR];
    return m;
  endfunction

endpackage

// File: rtl/ps2_mvmt_decoder_if.sv
// Output bus of the PS/2 movement decoder.
//   mvmt_out       {up, down, left, right}
//   code_out       last good scan code byte
//   code_valid_out one-cycle pulse when code_out updates
//   err_out        one-cycle pulse on parity, framing or timeout error
interface ps2_mvmt_decoder_if;
  import ps2_pkg::*;

  logic [MVMT_W-1:0] mvmt_out;
  logic [BYTE_W-1:0] code_out;
  logic              code_valid_out;
  logic              err_out;

  modport master (
    output mvmt_out,
    output code_out,
    output code_valid_out,
    output err_out
  );

  modport slave (
    input mvmt_out,
    input code_out,
    input code_valid_out,
    input err_out
  );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, ps2_clk glitch filter, 11-bit frame
// FSM with odd-parity/stop check and mid-frame timeout.
//   clk_in, rst_in        clock, synchronous active-high reset
//   ps2_clk_in/data_in    raw asynchronous PS/2 pins
//   byte_out              last good byte
//   valid_out             one-cycle pulse when byte_out updates
//   err_out               one-cycle pulse on any receive error
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              ps2_clk_in,
  input  logic              ps2_data_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic              valid_out,
  output logic              err_out
);

  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  logic              clk_filt;
  logic [FILT_W-1:0] filt_cnt;
  logic              flip_c;
  logic              fall_c;

  rx_state_t         state, state_d;
  logic [2:0]        bit_cnt, bit_cnt_d;
  logic [BYTE_W-1:0] shreg, shreg_d;
  logic              par, par_d;
  logic [TO_W-1:0]   to_cnt, to_cnt_d;
  logic [BYTE_W-1:0] byte_d;
  logic              valid_d;
  logic              err_d;

  // Pin synchronizers; idle PS/2 lines are high
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Level flips on the FILTER_LEN-th consecutive sample that disagrees with it
  assign flip_c = (clk_s != clk_filt) && (filt_cnt == FILT_W'(FILTER_LEN - 1));
  assign fall_c = flip_c && clk_filt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (flip_c) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FILT_W'(1);
    end
  end

  // Frame FSM state and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
      byte_out  <= '0;
      valid_out <= 1'b0;
      err_out   <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      par       <= par_d;
      to_cnt    <= to_cnt_d;
      byte_out  <= byte_d;
      valid_out <= valid_d;
      err_out   <= err_d;
    end
  end

  // Next state: one bit consumed per filtered falling edge
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    par_d     = par;
    to_cnt_d  = '0;
    byte_d    = byte_out;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    // Mid-frame watchdog; a falling edge in the expiry cycle wins
    if (state != IDLE) begin
      if (fall_c) begin
        to_cnt_d = '0;
      end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        shreg_d = '0;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt + TO_W'(1);
      end
    end

    if (fall_c) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d   = {data_s, shreg[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          if (data_s && (^{shreg, par})) begin
            byte_d  = shreg;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_mvmt_decoder.sv
// PS/2 keyboard to raycaster movement vector. Tracks make/break state of WASD
// and the arrow keys and presents {up, down, left, right}.
//   clk_in, rst_in        pixel clock, synchronous active-high reset
//   ps2_clk_in/data_in    raw asynchronous PS/2 pins
//   bus (master)          mvmt_out, code_out, code_valid_out, err_out
module ps2_mvmt_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  ps2_mvmt_decoder_if.master bus
);

  logic [BYTE_W-1:0] rx_byte;
  logic              rx_valid;
  logic              rx_err;

  logic [KEY_W-1:0]  keys, keys_d;
  logic              ext, ext_d;
  logic              brk, brk_d;
  logic [MVMT_W-1:0] mvmt_q;
  key_lookup_t       lk;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .byte_out    (rx_byte),
    .valid_out   (rx_valid),
    .err_out     (rx_err)
  );

  // Prefix and key-state update for each received byte
  always_comb begin
    keys_d = keys;
    ext_d  = ext;
    brk_d  = brk;
    lk     = key_lookup(ext, rx_byte);

    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else begin
        // Overrun codes drop everything so no key stays stuck
        if ((rx_byte == SC_OVR0) || (rx_byte == SC_OVR1)) begin
          keys_d = '0;
        end else if (lk.hit) begin
          keys_d[lk.idx] = !brk;
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // mvmt_out is taken from the next key state so it trails code_valid_out by one cycle
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      keys   <= '0;
      ext    <= 1'b0;
      brk    <= 1'b0;
      mvmt_q <= '0;
    end else begin
      keys   <= keys_d;
      ext    <= ext_d;
      brk    <= brk_d;
      mvmt_q <= mvmt_from_keys(keys_d);
    end
  end

  assign bus.mvmt_out       = mvmt_q;
  assign bus.code_out       = rx_byte;
  assign bus.code_valid_out = rx_valid;
  assign bus.err_out        = rx_err;

endmodule

// File: tb/tb_ps2_mvmt_decoder.sv
// Directed bench for ps2_mvmt_decoder: bit-banged PS/2 frames with
// hand-computed expected movement vectors, codes and error pulses.
module tb_ps2_mvmt_decoder;

  localparam int HALF = 20;
  localparam int IDLE_GAP = 30;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_mvmt_decoder_if bus ();

  ps2_mvmt_decoder #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (5000),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ps2_clk_in  (ps2_clk),
    .ps2_data_in (ps2_data),
    .bus         (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int valid_cyc = 0;
  int stop_cyc = 0;
  logic prev_valid = 1'b0;
  logic [7:0] last_code = '0;
  logic [3:0] mvmt_at_valid = '0;
  logic [3:0] mvmt_after = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample outputs 1 time unit after the edge
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    if (prev_valid) mvmt_after = bus.mvmt_out;
    prev_valid = bus.code_valid_out;
    if (bus.code_valid_out) begin
      valid_cnt++;
      last_code     = bus.code_out;
      valid_cyc     = cyc;
      mvmt_at_valid = bus.mvmt_out;
    end
    if (bus.err_out) err_cnt++;
  endtask

  // Hold ps2_clk at lvl for HALF cycles, optionally with a 2-cycle glitch
  task automatic phase(input logic lvl, input bit g);
    for (int i = 0; i < HALF; i++) begin
      ps2_clk = (g && (i == 12 || i == 13)) ? ~lvl : lvl;
      tick();
    end
  endtask

  task automatic send_bit(input logic b, input bit g);
    ps2_data = b;
    phase(1'b1, g);
    phase(1'b0, g);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop_b, input bit g);
    logic par;
    par = (~(^b)) ^ bad_par;
    valid_cnt = 0;
    err_cnt = 0;
    send_bit(1'b0, g);
    for (int i = 0; i < 8; i++) send_bit(b[i], g);
    send_bit(par, g);
    ps2_data = stop_b;
    phase(1'b1, g);
    stop_cyc = cyc;
    phase(1'b0, g);
    ps2_data = 1'b1;
    ps2_clk = 1'b1;
    repeat (IDLE_GAP) tick();
  endtask

  task automatic frame_ok(input string tag, input logic [7:0] b, input logic [3:0] exp_mvmt, input bit g);
    send_frame(b, 1'b0, 1'b1, g);
    chk({tag, " valid"}, 32'(valid_cnt), 32'd1);
    chk({tag, " code"}, 32'(last_code), 32'(b));
    chk({tag, " err"}, 32'(err_cnt), 32'd0);
    chk({tag, " mvmt"}, 32'(bus.mvmt_out), 32'(exp_mvmt));
  endtask

  initial begin
    int c0;
    int lat;

    // Reset state
    rst_in = 1'b1;
    repeat (4) tick();
    chk("rst mvmt", 32'(bus.mvmt_out), 32'h0);
    chk("rst code", 32'(bus.code_out), 32'h0);
    chk("rst valid", 32'(bus.code_valid_out), 32'h0);
    chk("rst err", 32'(bus.err_out), 32'h0);
    rst_in = 1'b0;
    repeat (20) tick();

    // W make, with latency and one-cycle-later mvmt update
    frame_ok("W make", 8'h1D, 4'b1000, 1'b0);
    chk("W valid latency", 32'(valid_cyc - stop_cyc), 32'd10);
    chk("W mvmt at valid", 32'(mvmt_at_valid), 32'h0);
    chk("W mvmt after valid", 32'(mvmt_after), 32'h8);
    frame_ok("W brk F0", 8'hF0, 4'b1000, 1'b0);
    frame_ok("W brk 1D", 8'h1D, 4'b0000, 1'b0);

    // Left arrow vs keypad 4
    frame_ok("LA E0", 8'hE0, 4'b0000, 1'b0);
    frame_ok("LA 6B", 8'h6B, 4'b0010, 1'b0);
    frame_ok("KP4 make", 8'h6B, 4'b0010, 1'b0);
    frame_ok("KP4 brk F0", 8'hF0, 4'b0010, 1'b0);
    frame_ok("KP4 brk 6B", 8'h6B, 4'b0010, 1'b0);
    frame_ok("LA rel E0", 8'hE0, 4'b0010, 1'b0);
    frame_ok("LA rel F0", 8'hF0, 4'b0010, 1'b0);
    frame_ok("LA rel 6B", 8'h6B, 4'b0000, 1'b0);

    // W and up arrow share the up bit
    frame_ok("W2 make", 8'h1D, 4'b1000, 1'b0);
    frame_ok("UA E0", 8'hE0, 4'b1000, 1'b0);
    frame_ok("UA 75", 8'h75, 4'b1000, 1'b0);
    frame_ok("W2 brk F0", 8'hF0, 4'b1000, 1'b0);
    frame_ok("W2 brk 1D", 8'h1D, 4'b1000, 1'b0);
    frame_ok("UA rel E0", 8'hE0, 4'b1000, 1'b0);
    frame_ok("UA rel F0", 8'hF0, 4'b1000, 1'b0);
    frame_ok("UA rel 75", 8'h75, 4'b0000, 1'b0);

    // Typematic repeat, prefix cleared by a miss, overrun
    frame_ok("W typ 1", 8'h1D, 4'b1000, 1'b0);
    frame_ok("W typ 2", 8'h1D, 4'b1000, 1'b0);
    frame_ok("miss F0", 8'hF0, 4'b1000, 1'b0);
    frame_ok("miss AA", 8'hAA, 4'b1000, 1'b0);
    frame_ok("W after miss", 8'h1D, 4'b1000, 1'b0);
    frame_ok("overrun FF", 8'hFF, 4'b0000, 1'b0);

    // Parity and stop-bit errors
    frame_ok("D make", 8'h23, 4'b0001, 1'b0);
    send_frame(8'h1D, 1'b1, 1'b1, 1'b0);
    chk("par err", 32'(err_cnt), 32'd1);
    chk("par valid", 32'(valid_cnt), 32'd0);
    chk("par mvmt", 32'(bus.mvmt_out), 32'h1);
    chk("par code", 32'(bus.code_out), 32'h23);
    frame_ok("stop pre F0", 8'hF0, 4'b0001, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0, 1'b0);
    chk("stop err", 32'(err_cnt), 32'd1);
    chk("stop valid", 32'(valid_cnt), 32'd0);
    chk("stop mvmt", 32'(bus.mvmt_out), 32'h1);
    chk("stop code", 32'(bus.code_out), 32'hF0);
    frame_ok("W after err", 8'h1D, 4'b1001, 1'b0);
    frame_ok("overrun 00", 8'h00, 4'b0000, 1'b0);

    // Timeout after start + 4 data bits
    valid_cnt = 0;
    err_cnt = 0;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    phase(1'b1, 1'b0);
    ps2_clk = 1'b0;
    c0 = cyc;
    lat = 0;
    for (int n = 0; n < 6000; n++) begin
      if (cyc - c0 == HALF) ps2_clk = 1'b1;
      tick();
      if (bus.err_out) begin
        lat = cyc - c0;
        break;
      end
    end
    ps2_clk = 1'b1;
    repeat (5) tick();
    chk("timeout latency", 32'(lat), 32'd5010);
    chk("timeout err", 32'(err_cnt), 32'd1);
    chk("timeout valid", 32'(valid_cnt), 32'd0);
    frame_ok("D after to", 8'h23, 4'b0001, 1'b0);
    frame_ok("D rel F0", 8'hF0, 4'b0001, 1'b0);
    frame_ok("D rel 23", 8'h23, 4'b0000, 1'b0);

    // Reset in the middle of a frame
    frame_ok("A make", 8'h1C, 4'b0010, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick();
    rst_in = 1'b1;
    tick();
    chk("midrst mvmt", 32'(bus.mvmt_out), 32'h0);
    chk("midrst code", 32'(bus.code_out), 32'h0);
    rst_in = 1'b0;
    err_cnt = 0;
    repeat (40) tick();
    chk("midrst no err", 32'(err_cnt), 32'd0);
    frame_ok("S after rst", 8'h1B, 4'b0100, 1'b0);

    // Glitched ps2_clk
    frame_ok("glitch F0", 8'hF0, 4'b0100, 1'b1);
    frame_ok("glitch 1B", 8'h1B, 4'b0000, 1'b1);
    frame_ok("glitch E0", 8'hE0, 4'b0000, 1'b1);
    frame_ok("glitch 74", 8'h74, 4'b0001, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
